// File: rtl/note_player.sv
// Single sequencer voice: holds a note for a number of beats and produces a
// signed sawtooth sample on each sample request.
module note_player #(
    parameter int unsigned NOTE_WIDTH     = 6,
    parameter int unsigned DURATION_WIDTH = 6,
    parameter int unsigned PHASE_WIDTH    = 22,
    parameter int unsigned SAMPLE_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      new_note,
    input  logic [NOTE_WIDTH-1:0]     note,
    input  logic [DURATION_WIDTH-1:0] duration,
    input  logic                      generate_next_sample,
    output logic                      note_done,
    output logic [SAMPLE_WIDTH-1:0]   sample_out,
    output logic                      new_sample_ready
);

    typedef enum logic {StIdle, StPlaying} state_e;

    state_e                    state_q, state_d;
    logic [NOTE_WIDTH-1:0]     note_q, note_d;
    logic [DURATION_WIDTH-1:0] count_q, count_d;
    logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
    logic [SAMPLE_WIDTH-1:0]   sample_q, sample_d;
    logic                      ready_q;

    logic [NOTE_WIDTH-1:0]  note_idx;
    logic [NOTE_WIDTH-1:0]  oct;
    logic [3:0]             semi;
    logic [13:0]            base;
    logic [PHASE_WIDTH-1:0] step;
    logic                   load;
    logic                   voiced;

    // Note 1 is A1; codes count semitones upward, so split into octave and semitone.
    assign note_idx = note_q - NOTE_WIDTH'(1);
    assign oct      = note_idx / NOTE_WIDTH'(12);
    assign semi     = 4'(note_idx % NOTE_WIDTH'(12));

    always_comb begin
        base = 14'd0;
        unique case (semi)
            4'd0:    base = 14'd4806;
            4'd1:    base = 14'd5092;
            4'd2:    base = 14'd5395;
            4'd3:    base = 14'd5715;
            4'd4:    base = 14'd6055;
            4'd5:    base = 14'd6415;
            4'd6:    base = 14'd6797;
            4'd7:    base = 14'd7201;
            4'd8:    base = 14'd7629;
            4'd9:    base = 14'd8083;
            4'd10:   base = 14'd8563;
            4'd11:   base = 14'd9072;
            default: base = 14'd0;
        endcase
    end

    always_comb begin
        step = '0;
        if (note_q != '0) begin
            step = PHASE_WIDTH'(base) << oct;
        end
    end

    assign load   = new_note && (duration != '0);
    // Sample qualification uses the state before this edge's transition.
    assign voiced = (state_q == StPlaying) && play && (note_q != '0);

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        count_d  = count_q;
        phase_d  = phase_q;
        sample_d = sample_q;

        if (load) begin
            note_d  = note;
            count_d = duration;
            phase_d = '0;
            state_d = StPlaying;
        end else if (state_q == StPlaying && play) begin
            if (beat) begin
                if (count_q == DURATION_WIDTH'(1)) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    count_d = count_q - DURATION_WIDTH'(1);
                end
            end
            if (generate_next_sample) begin
                phase_d = phase_q + step;
            end
        end

        if (generate_next_sample) begin
            if (voiced) begin
                // Offset-binary top bits to two's complement by flipping the MSB.
                sample_d = {~phase_d[PHASE_WIDTH-1], phase_d[PHASE_WIDTH-2 -: SAMPLE_WIDTH-1]};
            end else begin
                sample_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            note_q   <= '0;
            count_q  <= '0;
            phase_q  <= '0;
            sample_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            ready_q  <= generate_next_sample;
        end
    end

    assign note_done        = (state_q == StIdle);
    assign sample_out       = sample_q;
    assign new_sample_ready = ready_q;

endmodule
